// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared definitions for the multi-cycle RV32I sequencing controller:
//   - state_t       : controller FSM states
//   - OP_*          : RV32I major opcodes the controller recognises
//   - PC_SEL_*      : next-PC source encodings driven on pc_sel
//   - FAULT_*       : trap cause encodings driven on fault_code
//   - state_is_busy : busy decode shared by every user of state_t
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_IMEM    = 2'b10;
    localparam logic [1:0] FAULT_DMEM    = 2'b11;

    // The core is idle only when parked in HALT or trapped in FAULT.
    function automatic logic state_is_busy(input state_t s);
        logic b;
        case (s)
            ST_HALT:  b = 1'b0;
            ST_FAULT: b = 1'b0;
            default:  b = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier
// Combinational truth table mapping an RV32I major opcode to the control
// attributes the sequencer needs.
// Ports:
//   i_opcode    in  7  opcode from the Decode stage
//   o_legal     out 1  opcode is one the core executes
//   o_is_mem    out 1  load or store (needs a MEM cycle)
//   o_is_store  out 1  store
//   o_writes_rd out 1  instruction writes the register file
//   o_is_branch out 1  conditional branch
//   o_is_jump   out 1  JAL or JALR
module opcode_classifier
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_legal,
    output logic       o_is_mem,
    output logic       o_is_store,
    output logic       o_writes_rd,
    output logic       o_is_branch,
    output logic       o_is_jump
);

    // Opcode decode; anything unlisted is illegal with every attribute low.
    always_comb begin
        o_legal     = 1'b0;
        o_is_mem    = 1'b0;
        o_is_store  = 1'b0;
        o_writes_rd = 1'b0;
        o_is_branch = 1'b0;
        o_is_jump   = 1'b0;
        case (i_opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: begin
                o_legal     = 1'b1;
                o_writes_rd = 1'b1;
            end
            OP_LOAD: begin
                o_legal     = 1'b1;
                o_is_mem    = 1'b1;
                o_writes_rd = 1'b1;
            end
            OP_STORE: begin
                o_legal    = 1'b1;
                o_is_mem   = 1'b1;
                o_is_store = 1'b1;
            end
            OP_BRANCH: begin
                o_legal     = 1'b1;
                o_is_branch = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                o_legal     = 1'b1;
                o_is_jump   = 1'b1;
                o_writes_rd = 1'b1;
            end
            default: begin
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Sequencing FSM for the multi-cycle RV32I core: FETCH, DECODE, EXEC,
// MEM, WB plus HALT and the terminal FAULT trap.
// Parameters: MAX_WAIT (memory wait limit), CNT_W (instret width).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   halt_req                        pause after the current instruction
//   imem_req/imem_ready             instruction fetch handshake
//   ir_load, decode_en, alu_en      per-stage strobes
//   opcode, branch_taken            from Decode / ALU
//   dmem_req/dmem_we/dmem_ready     data memory handshake
//   rf_we, pc_en, pc_sel            writeback controls
//   busy, fault, fault_code         status
//   instret                         retired-instruction count
// Every output is a register loaded from the next state, so outputs
// change only on clock edges (or asynchronously to zero on reset).
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt_req,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             ir_load,
    output logic             decode_en,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic w_legal, w_is_mem, w_is_store, w_writes_rd, w_is_branch, w_is_jump;

    opcode_classifier u_classifier (
        .i_opcode    (opcode),
        .o_legal     (w_legal),
        .o_is_mem    (w_is_mem),
        .o_is_store  (w_is_store),
        .o_writes_rd (w_writes_rd),
        .o_is_branch (w_is_branch),
        .o_is_jump   (w_is_jump)
    );

    state_t              r_state,   w_next_state;
    logic [WAIT_W-1:0]   r_wait,    w_next_wait;
    logic [CNT_W-1:0]    r_instret, w_next_instret;
    logic                r_fault,   w_next_fault;
    logic [1:0]          r_fault_code, w_next_code;
    logic r_imem_req, r_ir_load, r_decode_en, r_alu_en, r_dmem_req, r_dmem_we;
    logic r_rf_we, r_pc_en, r_busy;
    logic [1:0] r_pc_sel;
    logic w_imem_req, w_ir_load, w_decode_en, w_alu_en, w_dmem_req, w_dmem_we;
    logic w_rf_we, w_pc_en, w_busy;
    logic [1:0] w_pc_sel;

    // Next-state, wait-counter, trap and retire-counter logic.
    always_comb begin
        w_next_state   = r_state;
        w_next_wait    = {WAIT_W{1'b0}};   // cleared on every state entry
        w_next_fault   = r_fault;
        w_next_code    = r_fault_code;
        w_next_instret = r_instret;
        case (r_state)
            ST_FETCH: begin
                // r_imem_req is low only in the first cycle after reset, so a
                // stray imem_ready there is not taken as a fetch response.
                // Ready is checked before the limit: ready wins over timeout.
                if (r_imem_req && imem_ready) begin
                    w_next_state = ST_DECODE;
                end else if (r_imem_req && (r_wait == WAIT_W'(MAX_WAIT))) begin
                    w_next_state = ST_FAULT;
                    w_next_fault = 1'b1;
                    w_next_code  = FAULT_IMEM;
                end else if (r_imem_req) begin
                    w_next_wait = r_wait + WAIT_W'(1);
                end else begin
                    w_next_wait = r_wait;
                end
            end
            ST_DECODE: begin
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (!w_legal) begin
                    w_next_state = ST_FAULT;
                    w_next_fault = 1'b1;
                    w_next_code  = FAULT_ILLEGAL;
                end else if (w_is_mem) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    w_next_state = ST_WB;
                end else if (r_wait == WAIT_W'(MAX_WAIT)) begin
                    w_next_state = ST_FAULT;
                    w_next_fault = 1'b1;
                    w_next_code  = FAULT_DMEM;
                end else begin
                    w_next_wait = r_wait + WAIT_W'(1);
                end
            end
            ST_WB: begin
                w_next_instret = r_instret + CNT_W'(1);
                if (halt_req) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (halt_req) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FAULT: begin
                w_next_state = ST_FAULT;
            end
            default: begin
                // Corrupted state encoding: trap rather than guess.
                w_next_state = ST_FAULT;
                w_next_fault = 1'b1;
                w_next_code  = FAULT_ILLEGAL;
            end
        endcase
    end

    // Moore output decode of the state being entered; registered below.
    // opcode/branch_taken are stable for the whole instruction, so sampling
    // them at the edge into WB or MEM matches their value inside that state.
    always_comb begin
        w_imem_req  = 1'b0;
        w_ir_load   = 1'b0;
        w_decode_en = 1'b0;
        w_alu_en    = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_rf_we     = 1'b0;
        w_pc_en     = 1'b0;
        w_pc_sel    = PC_SEL_PLUS4;
        w_busy      = state_is_busy(w_next_state);
        case (w_next_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
            end
            ST_DECODE: begin
                // The IR and the Decode register both capture the fetched
                // word in this one cycle, so opcode is valid in EXEC.
                w_ir_load   = 1'b1;
                w_decode_en = 1'b1;
            end
            ST_EXEC: begin
                w_alu_en = 1'b1;
            end
            ST_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_is_store;
            end
            ST_WB: begin
                w_rf_we = w_writes_rd;
                w_pc_en = 1'b1;
                if (w_is_jump) begin
                    w_pc_sel = PC_SEL_JUMP;
                end else if (w_is_branch && branch_taken) begin
                    w_pc_sel = PC_SEL_BRANCH;
                end else begin
                    w_pc_sel = PC_SEL_PLUS4;
                end
            end
            default: begin
                w_imem_req = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset clears every strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_wait       <= {WAIT_W{1'b0}};
            r_instret    <= {CNT_W{1'b0}};
            r_fault      <= 1'b0;
            r_fault_code <= FAULT_NONE;
            r_imem_req   <= 1'b0;
            r_ir_load    <= 1'b0;
            r_decode_en  <= 1'b0;
            r_alu_en     <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_rf_we      <= 1'b0;
            r_pc_en      <= 1'b0;
            r_pc_sel     <= PC_SEL_PLUS4;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_wait       <= w_next_wait;
            r_instret    <= w_next_instret;
            r_fault      <= w_next_fault;
            r_fault_code <= w_next_code;
            r_imem_req   <= w_imem_req;
            r_ir_load    <= w_ir_load;
            r_decode_en  <= w_decode_en;
            r_alu_en     <= w_alu_en;
            r_dmem_req   <= w_dmem_req;
            r_dmem_we    <= w_dmem_we;
            r_rf_we      <= w_rf_we;
            r_pc_en      <= w_pc_en;
            r_pc_sel     <= w_pc_sel;
            r_busy       <= w_busy;
        end
    end

    assign imem_req   = r_imem_req;
    assign ir_load    = r_ir_load;
    assign decode_en  = r_decode_en;
    assign alu_en     = r_alu_en;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign rf_we      = r_rf_we;
    assign pc_en      = r_pc_en;
    assign pc_sel     = r_pc_sel;
    assign busy       = r_busy;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign instret    = r_instret;

endmodule
